// File: rtl/elevator_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : elevator_scan_ctrl
// Description : SCAN (sweep) elevator controller. It drains floor requests
//               from a first-word-fall-through FIFO into a pending-request
//               bitmap and sweeps the cabin up and down, stopping at every
//               pending floor in the current sweep direction before turning
//               around. Each one-floor move takes TRAVEL_CYCLES cycles and
//               each stop holds the door open for DOOR_CYCLES cycles.
//
// Parameters  : NUM_FLOORS    - number of served floors (2..2**FLOOR_W)
//               FLOOR_W       - width of floor indices
//               TRAVEL_CYCLES - cycles per one-floor move (>=1)
//               DOOR_CYCLES   - cycles the door stays open (>=1)
//
// Ports       : clk          in   system clock
//               rst_n        in   asynchronous active-low reset
//               estop_i      in   emergency stop (only with ELEV_ESTOP_EN)
//               fifo_empty_i in   request FIFO empty
//               fifo_dout_i  in   requested floor (FWFT head)
//               fifo_rd_o    out  pop strobe, combinational
//               floor_o      out  current cabin floor
//               dir_o        out  00 up, 01 down, 11 idle
//               door_o       out  door open
//               pending_o    out  outstanding-request bitmap
//               req_err_o    out  one-cycle pulse: out-of-range request dropped
//
// Build macro : ELEV_ESTOP_EN - adds estop_i. While high, travel and door
//               timers freeze, floor and state hold, the door output is
//               forced low; request intake continues.
//
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_scan_ctrl #(
  parameter int NUM_FLOORS    = 16,
  parameter int FLOOR_W       = 4,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef ELEV_ESTOP_EN
  input  logic                  estop_i,
`endif
  input  logic                  fifo_empty_i,
  input  logic [FLOOR_W-1:0]    fifo_dout_i,
  output logic                  fifo_rd_o,
  output logic [FLOOR_W-1:0]    floor_o,
  output logic [1:0]            dir_o,
  output logic                  door_o,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic                  req_err_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int TCW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DCW = (DOOR_CYCLES   > 1) ? $clog2(DOOR_CYCLES)   : 1;

  localparam logic [TCW-1:0]        TRAVEL_LAST = TCW'(TRAVEL_CYCLES - 1);
  localparam logic [DCW-1:0]        DOOR_LAST   = DCW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0]    FLOOR_TOP   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W:0]      FLOOR_LIMIT = (FLOOR_W+1)'(NUM_FLOORS);
  localparam logic [NUM_FLOORS-1:0] FLOOR_ONE   = NUM_FLOORS'(1);

  localparam logic [1:0] DIR_UP   = 2'b00;
  localparam logic [1:0] DIR_DN   = 2'b01;
  localparam logic [1:0] DIR_IDLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MOVE_UP = 2'd1,
    ST_MOVE_DN = 2'd2,
    ST_DOOR    = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers and next-state values
  // --------------------------------------------------------------------------
  state_t                  state_q,      state_d;
  logic [FLOOR_W-1:0]      floor_q,      floor_d;
  logic [1:0]              dir_q,        dir_d;
  logic                    door_q,       door_d;
  logic [NUM_FLOORS-1:0]   pending_q,    pending_d;
  logic                    req_err_q,    req_err_d;
  logic [TCW-1:0]          travel_cnt_q, travel_cnt_d;
  logic [DCW-1:0]          door_cnt_q,   door_cnt_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                    w_run;
  logic                    w_req_in_range;
  logic [NUM_FLOORS-1:0]   w_req_onehot;
  logic [NUM_FLOORS-1:0]   w_above_mask;
  logic [NUM_FLOORS-1:0]   w_below_mask;
  logic                    w_above;
  logic                    w_below;
  logic                    w_here_req;
  logic [NUM_FLOORS-1:0]   w_set_mask;
  logic [NUM_FLOORS-1:0]   w_clr_mask;
  logic [NUM_FLOORS-1:0]   w_arrive_mask;
  logic [FLOOR_W-1:0]      w_step_floor;

`ifdef ELEV_ESTOP_EN
  assign w_run = ~estop_i;
`else
  assign w_run = 1'b1;
`endif

  // Popping is allowed whenever out of reset; an emergency stop does not
  // block intake.
  assign fifo_rd_o = rst_n & ~fifo_empty_i;

  assign w_req_in_range = ({1'b0, fifo_dout_i} < FLOOR_LIMIT);
  assign w_req_onehot   = FLOOR_ONE << fifo_dout_i;

  // Per-floor masks of the floors strictly above / below the cabin.
  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor_cmp
    assign w_above_mask[gi] = ((FLOOR_W+1)'(gi) > {1'b0, floor_q});
    assign w_below_mask[gi] = ((FLOOR_W+1)'(gi) < {1'b0, floor_q});
  end

  assign w_above = |(pending_q & w_above_mask);
  assign w_below = |(pending_q & w_below_mask);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    floor_d       = floor_q;
    dir_d         = dir_q;
    door_d        = door_q;
    travel_cnt_d  = travel_cnt_q;
    door_cnt_d    = door_cnt_q;
    req_err_d     = 1'b0;
    w_here_req    = 1'b0;
    w_set_mask    = '0;
    w_clr_mask    = '0;
    w_arrive_mask = '0;
    w_step_floor  = floor_q;

    // Request intake. A request for the floor the cabin is parked at (idle
    // or door open) is consumed directly instead of being stored.
    if (fifo_rd_o) begin
      if (!w_req_in_range) begin
        req_err_d = 1'b1;
      end else if ((fifo_dout_i == floor_q) &&
                   ((state_q == ST_IDLE) || (state_q == ST_DOOR))) begin
        w_here_req = 1'b1;
      end else begin
        w_set_mask = w_req_onehot;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (w_run) begin
          // A same-floor request opens the door at once; the pending bitmap
          // is re-evaluated when the door closes, treated as an up sweep.
          if (w_here_req) begin
            state_d    = ST_DOOR;
            door_d     = 1'b1;
            dir_d      = DIR_UP;
            door_cnt_d = '0;
          end else if (w_above) begin
            state_d      = ST_MOVE_UP;
            dir_d        = DIR_UP;
            travel_cnt_d = '0;
          end else if (w_below) begin
            state_d      = ST_MOVE_DN;
            dir_d        = DIR_DN;
            travel_cnt_d = '0;
          end
        end
      end

      ST_MOVE_UP, ST_MOVE_DN: begin
        if (w_run) begin
          if (travel_cnt_q == TRAVEL_LAST) begin
            travel_cnt_d = '0;
            if (state_q == ST_MOVE_UP) begin
              w_step_floor = (floor_q == FLOOR_TOP) ? floor_q : floor_q + FLOOR_W'(1);
            end else begin
              w_step_floor = (floor_q == '0) ? floor_q : floor_q - FLOOR_W'(1);
            end
            floor_d       = w_step_floor;
            w_arrive_mask = FLOOR_ONE << w_step_floor;
            // A request landing on the arrival edge for this floor counts as
            // served, just like an already pending one.
            if (|(w_arrive_mask & (pending_q | w_set_mask))) begin
              w_clr_mask = w_arrive_mask;
              state_d    = ST_DOOR;
              door_d     = 1'b1;
              door_cnt_d = '0;
            end else if (w_step_floor == floor_q) begin
              // Pinned at an end floor with nothing to serve: rest instead
              // of pushing past the shaft limit.
              state_d = ST_IDLE;
              dir_d   = DIR_IDLE;
            end
          end else begin
            travel_cnt_d = travel_cnt_q + TCW'(1);
          end
        end
      end

      ST_DOOR: begin
        if (w_here_req) begin
          // Same-floor call while the door is open: hold it for a full period.
          door_cnt_d = '0;
        end else if (w_run) begin
          if (door_cnt_q == DOOR_LAST) begin
            door_d       = 1'b0;
            door_cnt_d   = '0;
            travel_cnt_d = '0;
            // Continue the sweep, else reverse, else rest.
            if (dir_q == DIR_DN) begin
              if (w_below) begin
                state_d = ST_MOVE_DN;
                dir_d   = DIR_DN;
              end else if (w_above) begin
                state_d = ST_MOVE_UP;
                dir_d   = DIR_UP;
              end else begin
                state_d = ST_IDLE;
                dir_d   = DIR_IDLE;
              end
            end else begin
              if (w_above) begin
                state_d = ST_MOVE_UP;
                dir_d   = DIR_UP;
              end else if (w_below) begin
                state_d = ST_MOVE_DN;
                dir_d   = DIR_DN;
              end else begin
                state_d = ST_IDLE;
                dir_d   = DIR_IDLE;
              end
            end
          end else begin
            door_cnt_d = door_cnt_q + DCW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        dir_d   = DIR_IDLE;
        door_d  = 1'b0;
      end
    endcase

    // Arrival clears win over a simultaneous set of the same floor.
    pending_d = (pending_q | w_set_mask) & ~w_clr_mask;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      floor_q      <= '0;
      dir_q        <= DIR_IDLE;
      door_q       <= 1'b0;
      pending_q    <= '0;
      req_err_q    <= 1'b0;
      travel_cnt_q <= '0;
      door_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_q        <= dir_d;
      door_q       <= door_d;
      pending_q    <= pending_d;
      req_err_q    <= req_err_d;
      travel_cnt_q <= travel_cnt_d;
      door_cnt_q   <= door_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign floor_o   = floor_q;
  assign dir_o     = dir_q;
  assign pending_o = pending_q;
  assign req_err_o = req_err_q;
  // The emergency stop keeps the door shut even while a stop is in progress.
  assign door_o    = door_q & w_run;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_scan_ctrl
// Description : Scoreboard bench for elevator_scan_ctrl. The driver applies
//               directed and random requests, advances an abstract elevator
//               model one clock edge at a time and queues the expected
//               outputs; a monitor pops and compares after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_scan_ctrl;

  localparam int NF = 16;
  localparam int FW = 5;
  localparam int TC = 4;
  localparam int DC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [FW-1:0] fifo_dout = '0;
  logic          fifo_rd;
  logic [FW-1:0] floor_w;
  logic [1:0]    dir_w;
  logic          door_w;
  logic [NF-1:0] pending_w;
  logic          req_err;
  bit            cur_stop = 1'b0;
`ifdef ELEV_ESTOP_EN
  logic          estop = 1'b0;
`endif

  elevator_scan_ctrl #(
    .NUM_FLOORS   (NF),
    .FLOOR_W      (FW),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES  (DC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef ELEV_ESTOP_EN
    .estop_i     (estop),
`endif
    .fifo_empty_i(fifo_empty),
    .fifo_dout_i (fifo_dout),
    .fifo_rd_o   (fifo_rd),
    .floor_o     (floor_w),
    .dir_o       (dir_w),
    .door_o      (door_w),
    .pending_o   (pending_w),
    .req_err_o   (req_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int floor;
    int dir;
    int door;
    int pend;
    int err;
    int rd;
  } snap_t;

  snap_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  // --------------------------------------------------------------------------
  // Reference model: cabin position, heading (+1/-1/0), cycles left until
  // the next floor step, cycles of door time left, and a per-floor call list.
  // --------------------------------------------------------------------------
  int m_floor;
  int m_heading;
  int m_move_left;
  int m_door;
  bit m_pend[NF];

  function automatic int m_bitmap();
    int b = 0;
    for (int i = 0; i < NF; i++) if (m_pend[i]) b += (1 << i);
    return b;
  endfunction

  task automatic model_reset();
    m_floor = 0; m_heading = 0; m_move_left = 0; m_door = 0;
    for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
  endtask

  task automatic model_edge(input bit rd, input int req, input bit stop,
                            output bit err);
    bit up_any = 0;
    bit dn_any = 0;
    bit here   = 0;
    bit moving;
    for (int i = 0; i < NF; i++) begin
      if (m_pend[i] && i > m_floor) up_any = 1;
      if (m_pend[i] && i < m_floor) dn_any = 1;
    end
    moving = (m_door == 0) && (m_heading != 0);
    err = 0;
    if (rd) begin
      if (req >= NF)                      err = 1;
      else if (req == m_floor && !moving) here = 1;
      else                                m_pend[req] = 1;
    end
    if (m_door > 0) begin
      if (here) m_door = DC;
      else if (!stop) begin
        m_door--;
        if (m_door == 0) begin
          if ((m_heading > 0) ? up_any : dn_any) m_move_left = TC;
          else if ((m_heading > 0) ? dn_any : up_any) begin
            m_heading = -m_heading; m_move_left = TC;
          end else m_heading = 0;
        end
      end
    end else if (moving) begin
      if (!stop) begin
        m_move_left--;
        if (m_move_left == 0) begin
          m_floor += m_heading;
          m_move_left = TC;
          if (m_pend[m_floor]) begin
            m_pend[m_floor] = 0;
            m_door = DC;
          end
        end
      end
    end else if (!stop) begin
      if (here)        begin m_door = DC; m_heading = 1; end
      else if (up_any) begin m_heading = 1;  m_move_left = TC; end
      else if (dn_any) begin m_heading = -1; m_move_left = TC; end
    end
  endtask

  function automatic snap_t model_snap(bit err, bit rd, bit stop);
    snap_t s;
    s.floor = m_floor;
    s.dir   = (m_heading == 0) ? 3 : ((m_heading > 0) ? 0 : 1);
    s.door  = (m_door > 0 && !stop) ? 1 : 0;
    s.pend  = m_bitmap();
    s.err   = err;
    s.rd    = rd;
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // Comparison helper and monitor
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    snap_t s;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        vectors++;
        chk("floor",   int'(floor_w),   s.floor);
        chk("dir",     int'(dir_w),     s.dir);
        chk("door",    int'(door_w),    s.door);
        chk("pending", int'(pending_w), s.pend);
        chk("req_err", int'(req_err),   s.err);
        chk("fifo_rd", int'(fifo_rd),   s.rd);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic cycle(input bit empty, input int req);
    bit err;
    @(negedge clk);
    rst_n      = 1'b1;
    fifo_empty = empty;
    fifo_dout  = FW'(req);
`ifdef ELEV_ESTOP_EN
    estop      = cur_stop;
`endif
    model_edge(!empty, req, cur_stop, err);
    exp_q.push_back(model_snap(err, !empty, cur_stop));
  endtask

  task automatic push(input int f);
    cycle(1'b0, f);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 0);
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n      = 1'b0;
      fifo_empty = 1'b0;  // fifo_rd must stay low regardless
      fifo_dout  = FW'(5);
      model_reset();
      exp_q.push_back(model_snap(1'b0, 1'b0, cur_stop));
    end
  endtask

  task automatic wait_model_idle(input int budget);
    int n = 0;
    while (!(m_door == 0 && m_heading == 0) && n < budget) begin
      cycle(1'b1, 0);
      n++;
    end
    if (n >= budget) begin
      miscompares++;
      $display("FAIL settle: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic wait_model_door(input int budget);
    int n = 0;
    while (m_door == 0 && n < budget) begin
      cycle(1'b1, 0);
      n++;
    end
    if (n >= budget) begin
      miscompares++;
      $display("FAIL door_wait: got closed after %0d cycles expected open", n);
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    model_reset();
    hold_reset(3);

    // Single call from floor 0 to 5, full door period, back to idle.
    push(5);
    wait_model_idle(200);
    idle(2);

    // Three calls around floor 5: served 7, 9, then 2.
    push(9);
    push(2);
    push(7);
    wait_model_idle(400);

    // Out-of-range request is dropped with an error pulse.
    push(20);
    idle(3);

    // Door at floor 3, same-floor call after 6 open cycles restarts timer.
    push(3);
    wait_model_door(100);
    idle(5);
    push(3);
    wait_model_idle(100);

    // Async reset mid-transit from 2 toward 8.
    push(2);
    wait_model_idle(100);
    push(8);
    idle(6);
    @(negedge clk);
    fifo_empty = 1'b0;
    fifo_dout  = FW'(4);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    chk("rst_floor",   int'(floor_w),   0);
    chk("rst_dir",     int'(dir_w),     3);
    chk("rst_door",    int'(door_w),    0);
    chk("rst_pending", int'(pending_w), 0);
    chk("rst_fifo_rd", int'(fifo_rd),   0);
    model_reset();
    exp_q.push_back(model_snap(1'b0, 1'b0, cur_stop));
    hold_reset(1);

`ifdef ELEV_ESTOP_EN
    // Emergency stop for 10 cycles mid-transit with a call arriving meanwhile.
    push(6);
    idle(5);
    cur_stop = 1'b1;
    idle(4);
    push(11);
    idle(5);
    cur_stop = 1'b0;
    wait_model_idle(400);
`endif

    // Randomised traffic, including out-of-range calls and occasional resets.
    for (int i = 0; i < 3000; i++) begin
`ifdef ELEV_ESTOP_EN
      if ($urandom_range(0, 24) == 0) cur_stop = ~cur_stop;
`endif
      if ($urandom_range(0, 799) == 0) begin
        hold_reset(2);
      end else if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 9) == 0) push($urandom_range(NF, 31));
        else                           push($urandom_range(0, NF - 1));
      end else begin
        idle(1);
      end
    end
    cur_stop = 1'b0;
    wait_model_idle(2000);
    idle(2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
- Parametrised successor to the single-target elevator FSM. Serves up to NUM_FLOORS floors using SCAN (sweep) scheduling over a pending-request bitmap.
- Requests are drained from a first-word-fall-through request FIFO. Each floor transit takes TRAVEL_CYCLES cycles; the door is held open for DOOR_CYCLES cycles.
- Sits between the request FIFO and the cabin/door actuators and the status display.

Parameters:
- NUM_FLOORS, 16, number of served floors (2..2**FLOOR_W)
- FLOOR_W, 4, width of floor indices
- TRAVEL_CYCLES, 4, cycles per one-floor move (>=1)
- DOOR_CYCLES, 8, cycles the door stays open (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- fifo_empty  in  1  request FIFO empty
- fifo_dout  in  FLOOR_W  requested floor (FWFT head)
- fifo_rd  out  1  pop strobe, combinational
- floor  out  FLOOR_W  current cabin floor
- dir  out  2  00 up, 01 down, 11 idle
- door  out  1  door open
- pending  out  NUM_FLOORS  outstanding-request bitmap
- req_err  out  1  one-cycle pulse: out-of-range request dropped

Behaviour:
- Reset (async, rst_n low): floor=0, dir=11, door=0, pending=0, req_err=0, state IDLE, counters 0. fifo_rd=0 while rst_n is low.
- Intake:
  - fifo_rd = rst_n & !fifo_empty. One request per cycle; fifo_dout is sampled on the same edge.
  - Request >= NUM_FLOORS: dropped, req_err=1 for the next cycle.
  - Request == floor while in DOOR_OPEN or IDLE: not stored. In DOOR_OPEN it restarts the door timer; in IDLE it opens the door on the next edge.
  - Any other request sets pending[req]. Duplicate requests are idempotent.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. "Above" means any pending bit > floor; "below" means any pending bit < floor.
- IDLE, dir=11:
  - If above → MOVE_UP.
  - Else if below → MOVE_DOWN.
  - Else stay.
  - Up is preferred when both above and below are set.
- MOVE_UP / MOVE_DOWN, dir=00/01:
  - travel_cnt counts 0..TRAVEL_CYCLES-1.
  - On the terminal count: floor±1 and travel_cnt=0.
  - If pending[new floor] is set: clear it, door=1, → DOOR_OPEN, all on the same edge.
  - Otherwise keep moving.
  - Floor never leaves 0..NUM_FLOORS-1. The move direction is only entered when a target exists in that direction.
- DOOR_OPEN:
  - door=1 for exactly DOOR_CYCLES cycles; dir holds the sweep direction.
  - On expiry, door=0 and:
    - continue the current sweep if pending in that direction;
    - else reverse if pending opposite;
    - else → IDLE with dir=11.
  - A door opened from IDLE counts as sweep up for this decision.
- A request arriving on the same edge as arrival at that floor: pending bit is cleared (served), and the door timer starts from 0.
- Latency: a request popped at edge t, in IDLE, for floor f > floor:
  - MOVE_UP entered at t+1;
  - arrival and door=1 at t+1+(f-floor)*TRAVEL_CYCLES.
- Reset mid-move or mid-door: immediate return to reset values; pending requests are lost.

Optional Feature:
- Macro ELEV_ESTOP_EN adds input port estop (1 bit).
- With the macro defined, while estop=1:
  - travel_cnt and the door timer freeze; floor and state hold.
  - door is forced to 0, including in DOOR_OPEN.
  - fifo_rd is still asserted; intake and pending updates continue.
  - On release, operation resumes from the frozen counts.
- Without the macro: no estop port, behaviour as above.

Test Plan:
- Reset at floor 0; push 5 → MOVE_UP next cycle; floor=5 with door=1 after 20 cycles; door high exactly 8 cycles; then dir=11.
- From floor 5 (idle), push 9, 2, 7 on consecutive cycles → stops in order 7, 9, 2. pending goes 0x0284 → 0x0204 → 0x0004 → 0.
- Push 20 (with NUM_FLOORS=16) → fifo_rd=1, req_err pulses once, pending unchanged, state stays IDLE.
- Door open at floor 3, push 3 at door cycle 6 → timer restarts; door total high 6+8=14 cycles; pending[3] stays 0.
- Moving up from 2 toward 8; assert rst_n=0 mid-transit → floor=0, dir=11, door=0, pending=0 immediately, no fifo_rd.
- ELEV_ESTOP_EN: estop=1 for 10 cycles mid-transit → floor and travel_cnt frozen; arrival delayed by exactly 10 cycles; a request pushed during estop is present in pending.
